// File: rtl/mips_cpu_state_sequencer.sv
// Multi-cycle MIPS instruction sequencer: FETCH -> DECODE -> EXEC1 [-> EXEC2],
// with bus/muldiv stalls, halting on a zero next-PC and a retired-instruction counter.
module mips_cpu_state_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        waitrequest,
    input  logic [5:0]  opcode,
    input  logic [5:0]  fncode,
    input  logic [4:0]  regimm,
    input  logic [31:0] pc_next,
    input  logic        muldiv_busy,
    output logic [2:0]  state,
    output logic        active,
    output logic        stall,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        HALTED = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC1  = 3'd3,
        EXEC2  = 3'd4
    } state_t;

    state_t cur_state;
    state_t next_state;
    logic   is_load;
    logic   two_cycle;
    logic   mem_op;
    logic   muldiv_op;
    logic   exec1_hold;
    logic   complete;

    always_comb begin
        is_load    = (opcode >= 6'h20) && (opcode <= 6'h26);
        two_cycle  = is_load || ((opcode == 6'h01) && ((regimm == 5'h10) || (regimm == 5'h11)));
        mem_op     = is_load || (opcode == 6'h28) || (opcode == 6'h29) || (opcode == 6'h2B);
        muldiv_op  = (opcode == 6'h00) && (fncode >= 6'h18) && (fncode <= 6'h1B);
        exec1_hold = (mem_op && waitrequest) || (muldiv_op && muldiv_busy);
    end

    always_comb begin
        next_state = HALTED;
        stall      = 1'b0;
        complete   = 1'b0;
        case (cur_state)
            HALTED: next_state = HALTED;
            FETCH: begin
                stall      = waitrequest;
                next_state = waitrequest ? FETCH : DECODE;
            end
            DECODE: next_state = EXEC1;
            EXEC1: begin
                if (exec1_hold) begin
                    stall      = 1'b1;
                    next_state = EXEC1;
                end else if (two_cycle) begin
                    next_state = EXEC2;
                end else begin
                    complete   = 1'b1;
                    next_state = (pc_next == 32'h0) ? HALTED : FETCH;
                end
            end
            EXEC2: begin
                complete   = 1'b1;
                next_state = (pc_next == 32'h0) ? HALTED : FETCH;
            end
            // Encodings 5-7 fall through to HALTED.
            default: next_state = HALTED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= FETCH;
            retired   <= 32'h0;
        end else begin
            cur_state <= next_state;
            if (complete)
                retired <= retired + 32'd1;
        end
    end

    assign state  = cur_state;
    assign active = (cur_state != HALTED);

endmodule

// File: tb/tb_mips_cpu_state_sequencer.sv
// Directed bench for mips_cpu_state_sequencer: per-scenario tasks with hand-computed
// state sequences, stall counts and retired-counter values.
module tb_mips_cpu_state_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        waitrequest;
    logic [5:0]  opcode;
    logic [5:0]  fncode;
    logic [4:0]  regimm;
    logic [31:0] pc_next;
    logic        muldiv_busy;
    logic [2:0]  state;
    logic        active;
    logic        stall;
    logic [31:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    mips_cpu_state_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .waitrequest (waitrequest),
        .opcode      (opcode),
        .fncode      (fncode),
        .regimm      (regimm),
        .pc_next     (pc_next),
        .muldiv_busy (muldiv_busy),
        .state       (state),
        .active      (active),
        .stall       (stall),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; waitrequest = 1'b0; opcode = 6'h0; fncode = 6'h0;
        regimm = 5'h0; pc_next = 32'h10; muldiv_busy = 1'b0;
        #12;
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL reset_state got=%0d exp=1", state); end
        n_checks++; if (retired !== 32'h0) begin n_fail++; $display("FAIL reset_retired got=%h exp=0", retired); end
        n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL reset_active got=%b exp=1", active); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_addiu();
        logic [2:0] exp_s [4] = '{3'd1, 3'd2, 3'd3, 3'd1};
        logic [31:0] r0;
        int stalls = 0;
        opcode = 6'h09; pc_next = 32'h10; waitrequest = 1'b0;
        #1;
        r0 = retired;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (state !== exp_s[i]) begin n_fail++; $display("FAIL addiu_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
            if (stall) stalls++;
            if (i < 3) step();
        end
        n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL addiu_stalls got=%0d exp=0", stalls); end
        n_checks++; if (retired !== r0 + 32'd1) begin n_fail++; $display("FAIL addiu_retired got=%h exp=%h", retired, r0 + 32'd1); end
    endtask

    task automatic test_lw_wait();
        logic [2:0] exp_s [7] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd1};
        logic       wr    [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] r0;
        int stalls = 0;
        opcode = 6'h23; pc_next = 32'h14;
        r0 = retired;
        for (int i = 0; i < 7; i++) begin
            waitrequest = wr[i];
            #1;
            n_checks++; if (state !== exp_s[i]) begin n_fail++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
            n_checks++; if (stall !== wr[i]) begin n_fail++; $display("FAIL lw_stall[%0d] got=%b exp=%b", i, stall, wr[i]); end
            if (stall) stalls++;
            if (i < 6) step();
        end
        waitrequest = 1'b0;
        n_checks++; if (stalls != 2) begin n_fail++; $display("FAIL lw_stalls got=%0d exp=2", stalls); end
        n_checks++; if (retired !== r0 + 32'd1) begin n_fail++; $display("FAIL lw_retired got=%h exp=%h", retired, r0 + 32'd1); end
    endtask

    task automatic test_muldiv();
        opcode = 6'h00; fncode = 6'h1B; muldiv_busy = 1'b1; pc_next = 32'h18;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL divu_fetch_stall got=%b exp=0", stall); end
        step(); step();
        for (int k = 0; k < 6; k++) begin
            muldiv_busy = (k < 5);
            #1;
            n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL divu_exec1[%0d] got=%0d exp=3", k, state); end
            n_checks++; if (stall !== (k < 5)) begin n_fail++; $display("FAIL divu_stall[%0d] got=%b exp=%b", k, stall, (k < 5)); end
            step();
        end
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL divu_done got=%0d exp=1", state); end
        // Same busy stimulus on a non-muldiv instruction must not hold.
        fncode = 6'h21; muldiv_busy = 1'b1;
        step(); step();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL addu_stall got=%b exp=0", stall); end
        step();
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL addu_done got=%0d exp=1", state); end
        muldiv_busy = 1'b0;
    endtask

    task automatic test_wrap();
        waitrequest = 1'b1;
        #1;
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        #1;
        n_checks++; if (retired !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload got=%h exp=ffffffff", retired); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fetch_wait_stall got=%b exp=1", stall); end
        step();
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL fetch_hold got=%0d exp=1", state); end
        waitrequest = 1'b0; opcode = 6'h09; pc_next = 32'h20;
        step(); step(); step();
        n_checks++; if (retired !== 32'h0) begin n_fail++; $display("FAIL wrap_retired got=%h exp=00000000", retired); end
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL wrap_state got=%0d exp=1", state); end
    endtask

    task automatic test_halt();
        logic [31:0] r0;
        opcode = 6'h00; fncode = 6'h08; pc_next = 32'h0;
        r0 = retired;
        step(); step(); step();
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL jr_halt_state got=%0d exp=0", state); end
        n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL jr_halt_active got=%b exp=0", active); end
        n_checks++; if (retired !== r0 + 32'd1) begin n_fail++; $display("FAIL jr_halt_retired got=%h exp=%h", retired, r0 + 32'd1); end
        for (int i = 0; i < 10; i++) begin
            waitrequest = 1'($urandom); muldiv_busy = 1'($urandom);
            opcode = 6'($urandom); fncode = 6'($urandom); regimm = 5'($urandom);
            pc_next = $urandom;
            step();
            n_checks++; if (state !== 3'd0 || stall !== 1'b0) begin n_fail++; $display("FAIL halted_absorb[%0d] got=%0d/%b exp=0/0", i, state, stall); end
        end
        n_checks++; if (retired !== r0 + 32'd1) begin n_fail++; $display("FAIL halted_retired got=%h exp=%h", retired, r0 + 32'd1); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (state !== 3'd1 || active !== 1'b1) begin n_fail++; $display("FAIL halted_reset got=%0d/%b exp=1/1", state, active); end
        n_checks++; if (retired !== 32'h0) begin n_fail++; $display("FAIL halted_reset_retired got=%h exp=0", retired); end
        @(negedge clk);
        reset_n = 1'b1;
        waitrequest = 1'b0; muldiv_busy = 1'b0; regimm = 5'h0;
    endtask

    task automatic test_reset_mid();
        opcode = 6'h09; pc_next = 32'h30;
        step(); step(); step();
        n_checks++; if (retired !== 32'h1) begin n_fail++; $display("FAIL pre_bgezal_retired got=%h exp=1", retired); end
        opcode = 6'h01; regimm = 5'h11; pc_next = 32'h40;
        step(); step(); step();
        n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL bgezal_exec2 got=%0d exp=4", state); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL mid_reset_state got=%0d exp=1", state); end
        n_checks++; if (retired !== 32'h0) begin n_fail++; $display("FAIL mid_reset_retired got=%h exp=0", retired); end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        n_checks++; if (state !== 3'd2 || retired !== 32'h0) begin n_fail++; $display("FAIL post_reset got=%0d/%h exp=2/0", state, retired); end
    endtask

    initial begin
        test_reset();
        test_addiu();
        test_lw_wait();
        test_muldiv();
        test_wrap();
        test_halt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
